// File: rtl/pinch_capture.sv
// Two-finger pinch detector: tracks start/end finger positions and classifies zoom in/out.
// oREADY pulses two cycles after the ending report or timeout terminal; no backpressure, one pulse per touch.
module pinch_capture #(
   parameter logic [10:0] MIN_SPAN_DELTA  = 11'd16,
   parameter logic [19:0] RELEASE_TIMEOUT = 20'd500000
) (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic       iTOUCH_VALID,
   input  logic [3:0] iTOUCH_COUNT,
   input  logic [9:0] iX1,
   input  logic [9:0] iX2,
   input  logic [8:0] iY1,
   input  logic [8:0] iY2,
   output logic [9:0] oX1_START,
   output logic [9:0] oX2_START,
   output logic [9:0] oX1_END,
   output logic [9:0] oX2_END,
   output logic [8:0] oY1_START,
   output logic [8:0] oY2_START,
   output logic [8:0] oY1_END,
   output logic [8:0] oY2_END,
   output logic       oZOOM_OUT,
   output logic       oREADY
);

   typedef enum logic [1:0] {IDLE, TRACK, EVAL, WAIT_REL} state_t;

   state_t      state;
   logic [19:0] tmo_cnt;
   logic        lifted;
   logic [9:0]  x1_s, x2_s, x1_e, x2_e;
   logic [8:0]  y1_s, y2_s, y1_e, y2_e;

   function automatic logic [10:0] absdiff(input logic [10:0] a, input logic [10:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

   logic [10:0] dx_s, dy_s, dx_e, dy_e;
   logic [10:0] span_s, span_e, span_d;
   logic        accept, two_fingers, tmo_term;
   logic [19:0] tmo_next;

   assign dx_s   = absdiff({1'b0, x1_s}, {1'b0, x2_s});
   assign dy_s   = absdiff({2'b0, y1_s}, {2'b0, y2_s});
   assign dx_e   = absdiff({1'b0, x1_e}, {1'b0, x2_e});
   assign dy_e   = absdiff({2'b0, y1_e}, {2'b0, y2_e});
   assign span_s = dx_s + dy_s;
   assign span_e = dx_e + dy_e;
   assign span_d = absdiff(span_e, span_s);
   // Zero-length axes would make the consumer divide by zero, so such gestures are dropped.
   assign accept = (span_d >= MIN_SPAN_DELTA) && (dx_e != 11'd0) && (dy_e != 11'd0);

   assign two_fingers = iTOUCH_VALID && (iTOUCH_COUNT == 4'd2);
   assign tmo_term    = (tmo_cnt == RELEASE_TIMEOUT - 20'd1);
   assign tmo_next    = (&tmo_cnt) ? tmo_cnt : tmo_cnt + 20'd1;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state     <= IDLE;
         tmo_cnt   <= '0;
         lifted    <= 1'b0;
         x1_s <= '0; x2_s <= '0; x1_e <= '0; x2_e <= '0;
         y1_s <= '0; y2_s <= '0; y1_e <= '0; y2_e <= '0;
         oX1_START <= '0; oX2_START <= '0; oX1_END <= '0; oX2_END <= '0;
         oY1_START <= '0; oY2_START <= '0; oY1_END <= '0; oY2_END <= '0;
         oZOOM_OUT <= 1'b0;
         oREADY    <= 1'b0;
      end else begin
         oREADY <= 1'b0;
         case (state)
            IDLE: begin
               if (two_fingers) begin
                  x1_s <= iX1; x2_s <= iX2; y1_s <= iY1; y2_s <= iY2;
                  x1_e <= iX1; x2_e <= iX2; y1_e <= iY1; y2_e <= iY2;
                  tmo_cnt <= '0;
                  state   <= TRACK;
               end
            end
            TRACK: begin
               // A report arriving on the terminal cycle takes priority over the timeout.
               if (iTOUCH_VALID) begin
                  if (iTOUCH_COUNT == 4'd2) begin
                     x1_e <= iX1; x2_e <= iX2; y1_e <= iY1; y2_e <= iY2;
                     tmo_cnt <= '0;
                  end else begin
                     lifted <= (iTOUCH_COUNT == 4'd0);
                     state  <= EVAL;
                  end
               end else if (tmo_term) begin
                  lifted <= 1'b0;
                  state  <= EVAL;
               end else begin
                  tmo_cnt <= tmo_next;
               end
            end
            EVAL: begin
               tmo_cnt <= '0;
               state   <= WAIT_REL;
               if (accept) begin
                  oREADY    <= 1'b1;
                  oZOOM_OUT <= (span_e < span_s);
                  oX1_START <= x1_s; oX2_START <= x2_s; oY1_START <= y1_s; oY2_START <= y2_s;
                  oX1_END   <= x1_e; oX2_END   <= x2_e; oY1_END   <= y1_e; oY2_END   <= y2_e;
               end
            end
            WAIT_REL: begin
               // Once fingers already lifted, any further report means the touch is over.
               if (iTOUCH_VALID) begin
                  if ((iTOUCH_COUNT == 4'd0) || lifted) state <= IDLE;
                  else tmo_cnt <= '0;
               end else if (tmo_term) begin
                  state <= IDLE;
               end else begin
                  tmo_cnt <= tmo_next;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pinch_capture.sv
// Bench for pinch_capture: directed gestures plus random gestures, checked against a
// transaction-level model that predicts pulse timing, zoom direction and captured coordinates.
module tb_pinch_capture;

   localparam int RT = 8;

   typedef struct {
      logic [9:0] x1;
      logic [8:0] y1;
      logic [9:0] x2;
      logic [8:0] y2;
   } rep_t;

   typedef struct {
      int          cyc;
      logic [76:0] outs;
   } pulse_t;

   logic       iCLK = 1'b0;
   logic       iRST = 1'b1;
   logic       iTOUCH_VALID = 1'b0;
   logic [3:0] iTOUCH_COUNT = '0;
   logic [9:0] iX1 = '0, iX2 = '0;
   logic [8:0] iY1 = '0, iY2 = '0;
   logic [9:0] oX1_START, oX2_START, oX1_END, oX2_END;
   logic [8:0] oY1_START, oY2_START, oY1_END, oY2_END;
   logic       oZOOM_OUT, oREADY;

   pinch_capture #(.MIN_SPAN_DELTA(11'd16), .RELEASE_TIMEOUT(20'd8)) dut (
      .iCLK(iCLK), .iRST(iRST), .iTOUCH_VALID(iTOUCH_VALID), .iTOUCH_COUNT(iTOUCH_COUNT),
      .iX1(iX1), .iX2(iX2), .iY1(iY1), .iY2(iY2),
      .oX1_START(oX1_START), .oX2_START(oX2_START), .oX1_END(oX1_END), .oX2_END(oX2_END),
      .oY1_START(oY1_START), .oY2_START(oY2_START), .oY1_END(oY1_END), .oY2_END(oY2_END),
      .oZOOM_OUT(oZOOM_OUT), .oREADY(oREADY)
   );

   always #5 iCLK = ~iCLK;

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   pulse_t      pulses[$];
   rep_t        reps[$];
   logic [76:0] exp_out = '0;
   logic [76:0] dut_outs;

   assign dut_outs = {oX1_START, oY1_START, oX2_START, oY2_START,
                      oX1_END, oY1_END, oX2_END, oY2_END, oZOOM_OUT};

   always @(posedge iCLK) cyc <= cyc + 1;

   always @(negedge iCLK) begin
      if (oREADY === 1'b1) pulses.push_back('{cyc, dut_outs});
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send(input logic [3:0] c, input rep_t r, output int at);
      iTOUCH_VALID = 1'b1;
      iTOUCH_COUNT = c;
      iX1 = r.x1; iY1 = r.y1; iX2 = r.x2; iY2 = r.y2;
      at = cyc;
      tick();
      iTOUCH_VALID = 1'b0;
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic rep_t rand_rep();
      rep_t r;
      r.x1 = 10'($urandom_range(0, 1023));
      r.y1 = 9'($urandom_range(0, 511));
      r.x2 = 10'($urandom_range(0, 1023));
      r.y2 = 9'($urandom_range(0, 511));
      return r;
   endfunction

   function automatic int clampi(input int v, input int hi);
      return (v < 0) ? 0 : ((v > hi) ? hi : v);
   endfunction

   function automatic rep_t nudge(input rep_t p);
      rep_t r;
      r.x1 = 10'(clampi(int'(p.x1) + $urandom_range(0, 24) - 12, 1023));
      r.y1 = 9'(clampi(int'(p.y1) + $urandom_range(0, 24) - 12, 511));
      r.x2 = 10'(clampi(int'(p.x2) + $urandom_range(0, 24) - 12, 1023));
      r.y2 = 9'(clampi(int'(p.y2) + $urandom_range(0, 24) - 12, 511));
      return r;
   endfunction

   function automatic rep_t mk(input int x1, input int y1, input int x2, input int y2);
      rep_t r;
      r.x1 = 10'(x1); r.y1 = 9'(y1); r.x2 = 10'(x2); r.y2 = 9'(y2);
      return r;
   endfunction

   // Sends reps[] as one touch, ends it by a report (endc) or by silence, then
   // pokes WAIT_REL with a 2-finger report and releases with count=0.
   task automatic run_gesture(input string tag, input bit tmo_end, input logic [3:0] endc, input int gap);
      rep_t s, e;
      int   lc, end_cyc, dxe, dye, sps, spe;
      bit   acc, zoom;
      pulses.delete();
      s = reps[0];
      e = reps[reps.size() - 1];
      for (int i = 0; i < reps.size(); i++) begin
         if (i > 0) idle((gap < 0) ? int'($urandom_range(0, 7)) : gap);
         send(4'd2, reps[i], lc);
      end
      if (tmo_end) begin
         idle(RT);
         end_cyc = lc + RT;
      end else begin
         send(endc, rand_rep(), lc);
         end_cyc = lc;
      end
      idle(4);

      dxe  = iabs(int'(e.x1) - int'(e.x2));
      dye  = iabs(int'(e.y1) - int'(e.y2));
      sps  = iabs(int'(s.x1) - int'(s.x2)) + iabs(int'(s.y1) - int'(s.y2));
      spe  = dxe + dye;
      acc  = (iabs(spe - sps) >= 16) && (dxe != 0) && (dye != 0);
      zoom = (spe < sps);
      if (acc) exp_out = {s.x1, s.y1, s.x2, s.y2, e.x1, e.y1, e.x2, e.y2, zoom};

      check({tag, ":pulses"}, pulses.size(), acc ? 1 : 0);
      if (acc && pulses.size() > 0) begin
         check({tag, ":pulse_cyc"}, pulses[0].cyc, end_cyc + 2);
         check({tag, ":pulse_outs"}, pulses[0].outs, exp_out);
      end
      check({tag, ":hold"}, dut_outs, exp_out);

      send(4'd2, rand_rep(), lc);
      idle(3);
      check({tag, ":wait_rel"}, pulses.size(), acc ? 1 : 0);
      send(4'd0, rand_rep(), lc);
      idle(2);
      reps.delete();
   endtask

   initial begin
      int   lc;
      rep_t p;
      idle(3);
      check("reset_ready", oREADY, 1'b0);
      check("reset_outs", dut_outs, 77'd0);
      iRST = 1'b0;
      idle(2);

      reps.push_back(mk(100, 100, 200, 200));
      reps.push_back(mk(50, 50, 300, 300));
      run_gesture("pinch_out", 1'b0, 4'd0, 1);
      check("pinch_out_zoom", oZOOM_OUT, 1'b0);

      reps.push_back(mk(0, 0, 400, 240));
      reps.push_back(mk(150, 100, 250, 140));
      run_gesture("pinch_in", 1'b0, 4'd1, 2);
      check("pinch_in_zoom", oZOOM_OUT, 1'b1);

      reps.push_back(mk(100, 100, 200, 200));
      reps.push_back(mk(100, 100, 215, 200));
      run_gesture("delta15", 1'b0, 4'd0, 0);

      reps.push_back(mk(100, 100, 200, 200));
      reps.push_back(mk(100, 100, 216, 200));
      run_gesture("delta16", 1'b0, 4'd3, 0);

      reps.push_back(mk(100, 100, 200, 200));
      reps.push_back(mk(300, 0, 300, 400));
      run_gesture("zero_guard", 1'b0, 4'd0, 0);

      reps.push_back(mk(100, 100, 200, 200));
      reps.push_back(mk(120, 100, 180, 200));
      reps.push_back(mk(10, 20, 400, 300));
      run_gesture("timeout", 1'b1, 4'd0, RT - 1);

      // Reset one cycle before the expected pulse.
      pulses.delete();
      send(4'd2, mk(100, 100, 200, 200), lc);
      send(4'd2, mk(50, 50, 300, 300), lc);
      send(4'd0, mk(0, 0, 0, 0), lc);
      iRST = 1'b1;
      tick();
      iRST = 1'b0;
      check("rst_mid_ready", oREADY, 1'b0);
      check("rst_mid_outs", dut_outs, 77'd0);
      exp_out = '0;
      idle(4);
      check("rst_mid_pulses", pulses.size(), 0);

      for (int g = 0; g < 40; g++) begin
         int n;
         logic [3:0] c;
         n = $urandom_range(1, 4);
         p = rand_rep();
         reps.push_back(p);
         for (int i = 1; i < n; i++) begin
            p = ($urandom_range(0, 1) == 1) ? nudge(p) : rand_rep();
            reps.push_back(p);
         end
         c = 4'($urandom_range(0, 15));
         if (c == 4'd2) c = 4'd0;
         run_gesture($sformatf("rand%0d", g), ($urandom_range(0, 3) == 0), c, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pinch_capture.md
PINCH_CAPTURE -- requirements
Module: pinch_capture

Interface
REQ-001 Parameter MIN_SPAN_DELTA, default 11'd16: minimum change in finger span for a gesture to be accepted.
REQ-002 Parameter RELEASE_TIMEOUT, default 20'd500000: number of iCLK cycles without a touch report that ends tracking.
REQ-003 iCLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 iRST  input  1  reset; synchronous, active-high.
REQ-005 iTOUCH_VALID  input  1  one-cycle strobe marking a new touch-controller report.
REQ-006 iTOUCH_COUNT  input  4  number of fingers in the report; sampled only when iTOUCH_VALID=1.
REQ-007 iX1, iX2  input  10 each  finger 1 and finger 2 X coordinates; sampled with iTOUCH_VALID.
REQ-008 iY1, iY2  input  9 each  finger 1 and finger 2 Y coordinates; sampled with iTOUCH_VALID.
REQ-009 oX1_START, oX2_START, oX1_END, oX2_END  output  10 each  gesture start and end X coordinates.
REQ-010 oY1_START, oY2_START, oY1_END, oY2_END  output  9 each  gesture start and end Y coordinates.
REQ-011 oZOOM_OUT  output  1  1 = fingers closed (span shrank); 0 = fingers opened.
REQ-012 oREADY  output  1  one-cycle pulse; all coordinate outputs and oZOOM_OUT are valid and stable from this cycle until the next pulse.

Function
REQ-013 The FSM SHALL have four states: IDLE, TRACK, EVAL and WAIT_REL.
REQ-014 IDLE: on iTOUCH_VALID with count==2, latch the coordinates into both the start and end registers, clear the timeout counter, and go to TRACK; all other reports are ignored.
REQ-015 TRACK: on iTOUCH_VALID with count==2, update only the end registers and clear the timeout counter.
REQ-016 TRACK: on iTOUCH_VALID with count!=2, go to EVAL without updating the end registers.
REQ-017 TRACK: when no report arrives, increment the timeout counter; at RELEASE_TIMEOUT-1, go to EVAL.
REQ-018 TRACK: if a valid report and the timeout terminal count coincide, the report wins; the counter clears and the timeout is not taken.
REQ-019 EVAL (one cycle): span_s = |X1s-X2s| + |Y1s-Y2s| and span_e = |X1e-X2e| + |Y1e-Y2e|, both 11-bit unsigned with no overflow possible; absolute differences use the compare-then-subtract form.
REQ-020 EVAL: accept the gesture iff |span_e - span_s| >= MIN_SPAN_DELTA and |X1e-X2e| != 0 and |Y1e-Y2e| != 0 (divide-by-zero guard for the downstream consumer).
REQ-021 On accept: oREADY=1 in the cycle after EVAL; oZOOM_OUT = (span_e < span_s); copy internal start/end registers to the outputs in that same cycle.
REQ-022 On reject: no oREADY pulse; outputs keep their previous values.
REQ-023 Latency: the ending report (or the timeout terminal) in cycle N gives EVAL in N+1 and oREADY in N+2.
REQ-024 After EVAL go to WAIT_REL.
REQ-025 WAIT_REL: return to IDLE on iTOUCH_VALID with count==0, or after RELEASE_TIMEOUT idle cycles (same counter rules as TRACK); 2-finger reports here are ignored, so one touch produces at most one pulse.
REQ-026 When the ending report in TRACK has count==0, EVAL still proceeds to WAIT_REL; the next report (any count) or a timeout then returns to IDLE.
REQ-027 The timeout counter is 20 bits, saturates, and never wraps.
REQ-028 The EVAL and WAIT_REL states ignore iTOUCH_VALID for gesture purposes.
REQ-029 oREADY is never asserted on two consecutive cycles.

Reset
REQ-030 While iRST=1 at a clock edge: state=IDLE, timeout counter=0, oREADY=0, oZOOM_OUT=0, every coordinate output=0.
REQ-031 Reset mid-gesture (TRACK or EVAL) aborts the gesture with no oREADY pulse.
REQ-032 The first valid 2-finger report after iRST deasserts is handled as in IDLE.

Verification
REQ-033 Pinch out: report (100,100)/(200,200) then (50,50)/(300,300), then count=0 -> oREADY pulse 2 cycles after the count=0 strobe, oZOOM_OUT=0, START=(100,100,200,200), END=(50,50,300,300).
REQ-034 Pinch in: (0,0)/(400,240) then (150,100)/(250,140), then count=1 -> one pulse with oZOOM_OUT=1; a further 2-finger report in WAIT_REL produces no pulse.
REQ-035 Threshold: span change of 15 -> no pulse and outputs unchanged; span change of exactly 16 -> pulse.
REQ-036 Zero guard: end reports X1e=X2e=300 with a large Y change -> no pulse; FSM reaches IDLE after a count=0 report.
REQ-037 Timeout: with RELEASE_TIMEOUT=8, a valid gesture followed by silence -> EVAL 8 cycles after the last report, then a pulse; a report on the terminal cycle postpones the timeout.
REQ-038 Reset: assert iRST one cycle before the expected oREADY -> no pulse; all outputs read 0 on the following cycle.
